mem_port_arbiter: RTL and testbench

//  Owns the single byte-wide RAM port and shares it between instruction fetch (icache miss) and the MEM stage.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the byte-wide RAM port owned by mem_port_arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_flush;
   logic [31:0]       inst_rdata;
   logic              inst_valid;
   logic              inst_busy;

   logic              data_req;
   logic              data_rw;
   logic [1:0]        data_type;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic [31:0]       data_rdata;
   logic              data_valid;

   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wr;

   modport master (
      output inst_req, inst_addr, inst_flush,
      input  inst_rdata, inst_valid, inst_busy,
      output data_req, data_rw, data_type, data_addr, data_wdata,
      input  data_rdata, data_valid,
      output ram_din,
      input  ram_dout, ram_addr, ram_wr
   );

   modport slave (
      input  inst_req, inst_addr, inst_flush,
      output inst_rdata, inst_valid, inst_busy,
      input  data_req, data_rw, data_type, data_addr, data_wdata,
      output data_rdata, data_valid,
      input  ram_din,
      output ram_dout, ram_addr, ram_wr
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage, splitting
// 1/2/4-byte accesses into byte transfers. Define MEM_ARB_RR_EN for round-robin tie-break.
module mem_port_arbiter #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
   input logic               clk,
   input logic               rst,
   input logic               rdy,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;
   typedef enum logic       {OWN_INST, OWN_DATA}        owner_e;

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rbuf_q,  rbuf_d;
   logic [2:0]        len_q,   len_d;
   logic [2:0]        cnt_q,   cnt_d;
   logic              pend_q,  pend_d;
`ifdef MEM_ARB_RR_EN
   owner_e            last_q,  last_d;
`endif

   logic [2:0] data_len;
   logic [2:0] issue_idx;
   logic       issue_done;
   logic [2:0] byte_idx;
   logic       grant_data;

   always_comb begin
      unique case (bus.data_type)
         2'b10:   data_len = 3'd2;
         2'b11:   data_len = 3'd4;
         default: data_len = 3'd1;
      endcase
   end

   // pend_q: an address was issued last cycle, so its byte is on ram_din now.
   assign issue_idx  = cnt_q + {2'b00, pend_q};
   assign issue_done = (issue_idx >= len_q);
   assign byte_idx   = issue_done ? (len_q - 3'd1) : issue_idx;

`ifdef MEM_ARB_RR_EN
   assign grant_data = bus.data_req && (!bus.inst_req || (last_q == OWN_INST));
`else
   assign grant_data = bus.data_req;
`endif

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= OWN_INST;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_q  <= OWN_INST;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
`ifdef MEM_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every next-state variable gets a default first so no latch is inferred.
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
`ifdef MEM_ARB_RR_EN
      last_d  = last_q;
`endif
      if (!rdy) begin
         // The byte arriving during a stall is dropped and its address reissued.
         pend_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.inst_req || bus.data_req) begin
                  cnt_d  = '0;
                  pend_d = 1'b0;
                  rbuf_d = '0;
`ifdef MEM_ARB_RR_EN
                  last_d = grant_data ? OWN_DATA : OWN_INST;
`endif
                  if (grant_data) begin
                     owner_d = OWN_DATA;
                     addr_d  = bus.data_addr;
                     wdata_d = bus.data_wdata;
                     len_d   = data_len;
                     state_d = bus.data_rw ? S_WR : S_RD;
                  end else begin
                     owner_d = OWN_INST;
                     addr_d  = bus.inst_addr;
                     len_d   = 3'd4;
                     state_d = S_RD;
                  end
               end
            end
            S_RD: begin
               if ((owner_q == OWN_INST) && bus.inst_flush) begin
                  state_d = S_IDLE;
               end else begin
                  if (pend_q) begin
                     rbuf_d[{cnt_q[1:0], 3'b000} +: 8] = bus.ram_din;
                     cnt_d = cnt_q + 3'd1;
                     if (cnt_q + 3'd1 == len_q) state_d = S_DONE;
                  end
                  pend_d = !issue_done;
               end
            end
            S_WR: begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q + 3'd1 == len_q) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.ram_addr   = IDLE_ADDR;
      bus.ram_wr     = 1'b0;
      bus.ram_dout   = 8'h00;
      bus.inst_valid = 1'b0;
      bus.data_valid = 1'b0;
      unique case (state_q)
         S_RD: bus.ram_addr = addr_q + ADDR_W'(byte_idx);
         S_WR: begin
            bus.ram_addr = addr_q + ADDR_W'(byte_idx);
            bus.ram_wr   = rdy;
            bus.ram_dout = wdata_q[{byte_idx[1:0], 3'b000} +: 8];
         end
         S_DONE: begin
            bus.inst_valid = rdy && (owner_q == OWN_INST);
            bus.data_valid = rdy && (owner_q == OWN_DATA);
         end
         default: ;
      endcase
   end

   assign bus.inst_busy  = (owner_q == OWN_INST) && (state_q != S_IDLE);
   assign bus.inst_rdata = (owner_q == OWN_INST) ? rbuf_q : 32'h0;
   assign bus.data_rdata = (owner_q == OWN_DATA) ? rbuf_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: byte RAM model, expected responses and
// per-cycle RAM bus activity queued at stimulus time and checked at negedge.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 32;

   typedef struct {
      logic [31:0] data;
      bit          chk;
      int          cyc;
   } resp_t;

   typedef struct {
      int          cyc;
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  dout;
   } bus_t;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   resp_t inst_q[$];
   resp_t data_q[$];
   bus_t  tr_q[$];
   logic [7:0] mem [0:1023];

   mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .IDLE_ADDR(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: write on ram_wr, read data one cycle after its address.
   always @(posedge clk) begin
      if (bus.ram_wr) mem[bus.ram_addr[9:0]] = bus.ram_dout;
      bus.ram_din <= mem[bus.ram_addr[9:0]];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      resp_t r;
      bus_t  t;
      if (bus.inst_valid) begin
         if (inst_q.size() == 0) check("inst_valid_unexpected", {31'b0, bus.inst_valid}, 32'h0);
         else begin
            r = inst_q.pop_front();
            if (r.chk) check("inst_rdata", bus.inst_rdata, r.data);
            if (r.cyc >= 0) check("inst_valid_cycle", cyc, r.cyc);
         end
      end
      if (bus.data_valid) begin
         if (data_q.size() == 0) check("data_valid_unexpected", {31'b0, bus.data_valid}, 32'h0);
         else begin
            r = data_q.pop_front();
            if (r.chk) check("data_rdata", bus.data_rdata, r.data);
            if (r.cyc >= 0) check("data_valid_cycle", cyc, r.cyc);
         end
      end
      while (tr_q.size() > 0 && tr_q[0].cyc < cyc) begin
         t = tr_q.pop_front();
         check("bus_missed_cycle", cyc, t.cyc);
      end
      if (tr_q.size() > 0 && tr_q[0].cyc == cyc) begin
         t = tr_q.pop_front();
         check("ram_wr", {31'b0, bus.ram_wr}, {31'b0, t.wr});
         check("ram_addr", bus.ram_addr, t.addr);
         if (t.wr) check("ram_dout", {24'b0, bus.ram_dout}, {24'b0, t.dout});
      end else if (bus.ram_wr) begin
         check("ram_wr_unexpected", {31'b0, bus.ram_wr}, 32'h0);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // n read addresses plus the held last address, or n write beats, from cycle c0+1.
   task automatic push_trace(input int c0, input logic [31:0] a, input int n,
                             input logic wr, input logic [31:0] wd);
      for (int i = 0; i < n; i++)
         tr_q.push_back('{cyc: c0 + 1 + i, wr: wr, addr: a + i, dout: wd[8*i +: 8]});
      if (!wr) tr_q.push_back('{cyc: c0 + n + 1, wr: 1'b0, addr: a + n - 1, dout: 8'h00});
   endtask

   // Requesters drop req after seeing their valid pulse.
   task automatic finish_reqs(input int budget);
      bit di, dd;
      int k = 0;
      while ((bus.inst_req || bus.data_req) && k < budget) begin
         smp();
         di = bus.inst_valid;
         dd = bus.data_valid;
         nxt();
         if (di) bus.inst_req = 1'b0;
         if (dd) bus.data_req = 1'b0;
         k++;
      end
      if (bus.inst_req || bus.data_req) begin
         check("timeout_req_pending", {30'b0, bus.inst_req, bus.data_req}, 32'h0);
         bus.inst_req = 1'b0;
         bus.data_req = 1'b0;
      end
      repeat (3) nxt();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ram_addr"},   bus.ram_addr, 32'h0);
      check({tag, "_ram_wr"},     {31'b0, bus.ram_wr}, 32'h0);
      check({tag, "_ram_dout"},   {24'b0, bus.ram_dout}, 32'h0);
      check({tag, "_inst_valid"}, {31'b0, bus.inst_valid}, 32'h0);
      check({tag, "_data_valid"}, {31'b0, bus.data_valid}, 32'h0);
      check({tag, "_inst_busy"},  {31'b0, bus.inst_busy}, 32'h0);
      check({tag, "_inst_rdata"}, bus.inst_rdata, 32'h0);
      check({tag, "_data_rdata"}, bus.data_rdata, 32'h0);
   endtask

   task automatic start_data(input logic rw, input logic [1:0] ty,
                             input logic [31:0] a, input logic [31:0] wd);
      bus.data_rw    = rw;
      bus.data_type  = ty;
      bus.data_addr  = a;
      bus.data_wdata = wd;
      bus.data_req   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   c0;
      logic busy_exp;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5C;
      {mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]} = {8'h13, 8'h05, 8'h00, 8'h00};
      {mem[10'h000], mem[10'h001], mem[10'h002], mem[10'h003]} = {8'h37, 8'h12, 8'h00, 8'h00};
      {mem[10'h040], mem[10'h041]} = {8'hAA, 8'hBB};
      {mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      mem[10'h3FF] = 8'h5A;

      rst = 1'b1;
      rdy = 1'b1;
      bus.inst_req = 1'b0; bus.inst_addr = '0; bus.inst_flush = 1'b0;
      bus.data_req = 1'b0; bus.data_rw = 1'b0; bus.data_type = 2'b00;
      bus.data_addr = '0; bus.data_wdata = '0;
      repeat (2) nxt();
      smp();
      check_reset_outputs("reset");
      nxt();
      rst = 1'b0;
      nxt();

      // Word fetch 0x100
      c0 = cyc;
      bus.inst_addr = 32'h100;
      bus.inst_req  = 1'b1;
      inst_q.push_back('{data: 32'h0000_0513, chk: 1'b1, cyc: c0 + 6});
      push_trace(c0, 32'h100, 4, 1'b0, 32'h0);
      for (int k = 1; k <= 6; k++) begin
         nxt();
         smp();
         check("fetch_busy", {31'b0, bus.inst_busy}, 32'h1);
      end
      nxt();
      bus.inst_req = 1'b0;
      smp();
      check("fetch_busy_after", {31'b0, bus.inst_busy}, 32'h0);
      repeat (2) nxt();

      // SB 0x20: single write beat
      c0 = cyc;
      start_data(1'b1, 2'b01, 32'h20, 32'hAABB_CCDD);
      data_q.push_back('{data: 32'h0, chk: 1'b0, cyc: c0 + 2});
      push_trace(c0, 32'h20, 1, 1'b1, 32'hAABB_CCDD);
      finish_reqs(10);
      check("sb_byte", {24'b0, mem[10'h020]}, 32'h0000_00DD);
      check("sb_neighbour_kept", {24'b0, mem[10'h021]}, {24'b0, 8'h21 ^ 8'h5C});

      // LH 0x40 and fetch 0x0 in the same cycle
      c0 = cyc;
      start_data(1'b0, 2'b10, 32'h40, 32'h0);
      bus.inst_addr = 32'h0;
      bus.inst_req  = 1'b1;
`ifdef MEM_ARB_RR_EN
      busy_exp = 1'b1;
      inst_q.push_back('{data: 32'h0000_1237, chk: 1'b1, cyc: c0 + 6});
      data_q.push_back('{data: 32'h0000_BBAA, chk: 1'b1, cyc: c0 + 11});
      push_trace(c0, 32'h0, 4, 1'b0, 32'h0);
      push_trace(c0 + 7, 32'h40, 2, 1'b0, 32'h0);
`else
      busy_exp = 1'b0;
      data_q.push_back('{data: 32'h0000_BBAA, chk: 1'b1, cyc: c0 + 4});
      inst_q.push_back('{data: 32'h0000_1237, chk: 1'b1, cyc: c0 + 11});
      push_trace(c0, 32'h40, 2, 1'b0, 32'h0);
      push_trace(c0 + 5, 32'h0, 4, 1'b0, 32'h0);
`endif
      nxt();
      smp();
      check("tie_first_busy", {31'b0, bus.inst_busy}, {31'b0, busy_exp});
      finish_reqs(30);

      // Fetch 0x200 flushed in cycle 3, new fetch 0x300 taken in cycle 4
      c0 = cyc;
      bus.inst_addr = 32'h200;
      bus.inst_req  = 1'b1;
      for (int i = 0; i < 3; i++)
         tr_q.push_back('{cyc: c0 + 1 + i, wr: 1'b0, addr: 32'h200 + i, dout: 8'h00});
      repeat (3) nxt();
      bus.inst_flush = 1'b1;
      nxt();
      bus.inst_flush = 1'b0;
      bus.inst_addr  = 32'h300;
      inst_q.push_back('{data: 32'hDEAD_BEEF, chk: 1'b1, cyc: c0 + 10});
      push_trace(c0 + 4, 32'h300, 4, 1'b0, 32'h0);
      smp();
      check("flush_idle_busy", {31'b0, bus.inst_busy}, 32'h0);
      check("flush_idle_addr", bus.ram_addr, 32'h0);
      finish_reqs(20);

      // SW 0x80 with rdy low in cycles 2-4
      c0 = cyc;
      start_data(1'b1, 2'b11, 32'h80, 32'h1122_3344);
      tr_q.push_back('{cyc: c0 + 1, wr: 1'b1, addr: 32'h80, dout: 8'h44});
      tr_q.push_back('{cyc: c0 + 5, wr: 1'b1, addr: 32'h81, dout: 8'h33});
      tr_q.push_back('{cyc: c0 + 6, wr: 1'b1, addr: 32'h82, dout: 8'h22});
      tr_q.push_back('{cyc: c0 + 7, wr: 1'b1, addr: 32'h83, dout: 8'h11});
      data_q.push_back('{data: 32'h0, chk: 1'b0, cyc: c0 + 8});
      nxt();
      nxt();
      rdy = 1'b0;
      smp();
      check("stall_no_write", {31'b0, bus.ram_wr}, 32'h0);
      repeat (3) nxt();
      rdy = 1'b1;
      finish_reqs(20);

      // Reset in cycle 3 of a word load
      c0 = cyc;
      start_data(1'b0, 2'b11, 32'h80, 32'h0);
      for (int i = 0; i < 3; i++)
         tr_q.push_back('{cyc: c0 + 1 + i, wr: 1'b0, addr: 32'h80 + i, dout: 8'h00});
      repeat (3) nxt();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      bus.data_req = 1'b0;
      smp();
      check_reset_outputs("midrst");
      repeat (6) nxt();

      // LW 0x80 reads back the stored word
      c0 = cyc;
      start_data(1'b0, 2'b11, 32'h80, 32'h0);
      data_q.push_back('{data: 32'h1122_3344, chk: 1'b1, cyc: c0 + 6});
      push_trace(c0, 32'h80, 4, 1'b0, 32'h0);
      finish_reqs(20);

      // LH across the top of the address space
      c0 = cyc;
      start_data(1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0);
      data_q.push_back('{data: 32'h0000_375A, chk: 1'b1, cyc: c0 + 4});
      push_trace(c0, 32'hFFFF_FFFF, 2, 1'b0, 32'h0);
      finish_reqs(20);

      // LB (type 00) at 0x41 with a flush that must not disturb it
      c0 = cyc;
      start_data(1'b0, 2'b00, 32'h41, 32'h0);
      data_q.push_back('{data: 32'h0000_00BB, chk: 1'b1, cyc: c0 + 3});
      push_trace(c0, 32'h41, 1, 1'b0, 32'h0);
      nxt();
      bus.inst_flush = 1'b1;
      nxt();
      bus.inst_flush = 1'b0;
      finish_reqs(20);

      // Fetch 0x100 with rdy low in cycle 3: data must still assemble correctly
      bus.inst_addr = 32'h100;
      bus.inst_req  = 1'b1;
      inst_q.push_back('{data: 32'h0000_0513, chk: 1'b1, cyc: -1});
      repeat (3) nxt();
      rdy = 1'b0;
      nxt();
      rdy = 1'b1;
      finish_reqs(30);

      check("inst_q_drained", inst_q.size(), 32'h0);
      check("data_q_drained", data_q.size(), 32'h0);
      check("bus_q_drained", tr_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
